// File: rtl/nbit_mesh_pkg.sv
// Shared types and helpers for the N-bit mesh array.
// FSM encoding, latency bounds and flat-vector offset helpers.
package nbit_mesh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 16;

    function automatic bit lat_ok(int l);
        return (l >= LAT_MIN) && (l <= LAT_MAX);
    endfunction

    function automatic int cell_off(int r, int c, int cols, int w);
        return (r * cols + c) * w;
    endfunction

    function automatic int sum_off(int c, int sw);
        return c * sw;
    endfunction

endpackage

// File: rtl/nbit_mesh_array_if.sv
// Loader/readout bundle for the mesh array.
// master = row loader and readout side, slave = the mesh.
interface nbit_mesh_array_if #(
    parameter int W    = 2,
    parameter int COLS = 26,
    parameter int ROWS = 18
) ();
    localparam int RW = $clog2(ROWS);
    localparam int SW = W + $clog2(ROWS + 1);

    logic                     wr_en;
    logic [RW-1:0]            wr_row;
    logic [COLS*W-1:0]        wr_data;
    logic                     clear;
    logic                     start;
    logic                     mode;
    logic                     busy;
    logic                     out_valid;
    logic [ROWS*COLS*W-1:0]   out_mesh;
    logic [COLS*SW-1:0]       out_colsum;
    logic                     wr_err;

    modport master (
        output wr_en, wr_row, wr_data, clear, start, mode,
        input  busy, out_valid, out_mesh, out_colsum, wr_err
    );

    modport slave (
        input  wr_en, wr_row, wr_data, clear, start, mode,
        output busy, out_valid, out_mesh, out_colsum, wr_err
    );
endinterface

// File: rtl/mesh_colsum.sv
// Reduction of one mesh column of ROWS W-bit cells.
// inv bit-inverts every cell before it is added.
module mesh_colsum #(
    parameter int W    = 2,
    parameter int ROWS = 18,
    parameter int SW   = W + $clog2(ROWS + 1)
) (
    input  logic [ROWS*W-1:0] cells,
    input  logic              inv,
    output logic [SW-1:0]     sum
);
    logic [SW-1:0] acc;
    logic [W-1:0]  v;

    always_comb begin
        acc = '0;
        v   = '0;
        for (int r = 0; r < ROWS; r++) begin
            v   = cells[r*W +: W] ^ {W{inv}};
            acc = acc + SW'(v);
        end
    end

    assign sum = acc;
endmodule

// File: rtl/nbit_mesh_array.sv
// ROWS x COLS mesh of W-bit cells, row-loaded, with snapshot
// and fixed-latency per-column sums.
module nbit_mesh_array
    import nbit_mesh_pkg::*;
#(
    parameter int W       = 2,
    parameter int COLS    = 26,
    parameter int ROWS    = 18,
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic rst_n,
    nbit_mesh_array_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int SW = W + $clog2(ROWS + 1);
    localparam int RB = COLS * W;

    if (!lat_ok(LATENCY)) begin : g_bad_lat
        $error("nbit_mesh_array: LATENCY must be 2..16");
    end

    state_t state, nxt;

    logic [RB-1:0]          arr [ROWS];
    logic [ROWS*RB-1:0]     mesh_q;
    logic                   mode_q;
    logic [3:0]             cnt;
    logic [COLS*SW-1:0]     sum_c;
    logic [COLS*SW-1:0]     sum_q;
    logic [COLS*SW-1:0]     colsum_q;
    logic                   wr_err_q;
    logic                   busy;
    logic                   vld;
    logic                   go;
    logic                   row_ok;
    logic                   wr_ok;
    logic                   wr_bad;
    logic                   clr_ok;

    assign row_ok = int'(bus.wr_row) < ROWS;
    assign go     = (state == IDLE) && bus.start;
    assign clr_ok = bus.clear && !busy;
    assign wr_ok  = bus.wr_en && !busy && row_ok;
    assign wr_bad = bus.wr_en && (busy || !row_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.start) nxt = RUN;
            RUN:     if (cnt == '0) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        vld  = (state == DONE);
    end

    // clear beats a same-cycle write; snapshot sees the pre-edge array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) arr[r] <= '0;
            mesh_q   <= '0;
            mode_q   <= 1'b0;
            cnt      <= '0;
            sum_q    <= '0;
            colsum_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
            if (clr_ok) begin
                for (int r = 0; r < ROWS; r++) arr[r] <= '0;
            end else if (wr_ok) begin
                arr[bus.wr_row] <= bus.wr_data;
            end
            if (go) begin
                for (int r = 0; r < ROWS; r++) mesh_q[r*RB +: RB] <= arr[r];
                mode_q <= bus.mode;
                cnt    <= 4'(LATENCY - 1);
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == RUN && cnt == 4'(LATENCY - 1)) sum_q <= sum_c;
            if (state == RUN && cnt == '0) colsum_q <= sum_q;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS*W-1:0] colv;
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign colv[r*W +: W] = mesh_q[cell_off(r, c, COLS, W) +: W];
        end
        mesh_colsum #(
            .W    (W),
            .ROWS (ROWS),
            .SW   (SW)
        ) u_col (
            .cells (colv),
            .inv   (mode_q),
            .sum   (sum_c[sum_off(c, SW) +: SW])
        );
    end

    assign bus.busy       = busy;
    assign bus.out_valid  = vld;
    assign bus.out_mesh   = mesh_q;
    assign bus.out_colsum = colsum_q;
    assign bus.wr_err     = wr_err_q;

    logic unused_rw;
    assign unused_rw = ^RW;
endmodule

// File: tb/tb_nbit_mesh_array.sv
// Directed bench for nbit_mesh_array: default 2x26x18 instance
// plus a W=4/COLS=8/ROWS=5/LATENCY=2 instance.
module tb_nbit_mesh_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nbit_mesh_array_if #(.W(2), .COLS(26), .ROWS(18)) m ();
    nbit_mesh_array_if #(.W(4), .COLS(8),  .ROWS(5))  s ();

    nbit_mesh_array #(.W(2), .COLS(26), .ROWS(18), .LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    nbit_mesh_array #(.W(4), .COLS(8), .ROWS(5), .LATENCY(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s)
    );

    typedef struct {
        bit         md;
        int         prow;
        logic [1:0] pval;
        int         exp;
    } vec_t;

    int nerr = 0;
    int nchk = 0;

    logic [51:0] mrow [18];
    logic [1:0]  pat [6];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [51:0] fill(logic [1:0] v);
        return {26{v}};
    endfunction

    task automatic wr(int row, logic [51:0] d);
        m.wr_en   = 1'b1;
        m.wr_row  = 5'(row);
        m.wr_data = d;
        tick();
        m.wr_en   = 1'b0;
        if (row < 18) mrow[row] = d;
    endtask

    task automatic load_base();
        for (int i = 0; i < 18; i++) wr(i, fill(pat[i % 6]));
    endtask

    task automatic start_pulse(bit md);
        m.start = 1'b1;
        m.mode  = md;
        tick();
        m.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m.out_valid && n < 20);
    endtask

    task automatic chk_sums(string nm, int exp);
        for (int c = 0; c < 26; c++)
            chk($sformatf("%s_col%0d", nm, c), 64'(m.out_colsum[c*7 +: 7]), 64'(exp));
    endtask

    task automatic chk_mesh(string nm);
        for (int r = 0; r < 18; r++)
            chk($sformatf("%s_row%0d", nm, r), 64'(m.out_mesh[r*52 +: 52]), 64'(mrow[r]));
    endtask

    task automatic chk_pulse_end(string nm);
        chk({nm, "_busy_at_valid"}, 64'(m.busy), 64'd1);
        tick();
        chk({nm, "_valid_one_cycle"}, 64'(m.out_valid), 64'd0);
        chk({nm, "_busy_drop"}, 64'(m.busy), 64'd0);
    endtask

    vec_t tbl [5];

    initial begin
        int n;
        int seen;
        pat = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        tbl[0] = '{md: 1'b0, prow: -1, pval: 2'b00, exp: 27};
        tbl[1] = '{md: 1'b1, prow: -1, pval: 2'b00, exp: 27};
        tbl[2] = '{md: 1'b1, prow:  0, pval: 2'b11, exp: 25};
        tbl[3] = '{md: 1'b0, prow:  0, pval: 2'b11, exp: 29};
        tbl[4] = '{md: 1'b1, prow:  2, pval: 2'b00, exp: 29};

        for (int r = 0; r < 18; r++) mrow[r] = '0;
        m.wr_en = 0; m.wr_row = '0; m.wr_data = '0;
        m.clear = 0; m.start = 0; m.mode = 0;
        s.wr_en = 0; s.wr_row = '0; s.wr_data = '0;
        s.clear = 0; s.start = 0; s.mode = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_valid", 64'(m.out_valid), 64'd0);
        chk("rst_mesh_or", 64'(|m.out_mesh), 64'd0);
        chk("rst_colsum_or", 64'(|m.out_colsum), 64'd0);
        chk("rst_wr_err", 64'(m.wr_err), 64'd0);

        for (int v = 0; v < 5; v++) begin
            load_base();
            if (tbl[v].prow >= 0) wr(tbl[v].prow, fill(tbl[v].pval));
            start_pulse(tbl[v].md);
            wait_done(n);
            chk($sformatf("v%0d_latency", v), 64'(n), 64'd4);
            chk_sums($sformatf("v%0d", v), tbl[v].exp);
            chk_mesh($sformatf("v%0d", v));
            chk_pulse_end($sformatf("v%0d", v));
        end

        // out-of-range row and write while busy
        load_base();
        m.wr_en = 1'b1; m.wr_row = 5'd18; m.wr_data = fill(2'b11);
        tick();
        m.wr_en = 1'b0;
        chk("oor_wr_err", 64'(m.wr_err), 64'd1);
        tick();
        chk("oor_wr_err_clr", 64'(m.wr_err), 64'd0);
        start_pulse(1'b0);
        m.wr_en = 1'b1; m.wr_row = 5'd3; m.wr_data = fill(2'b11);
        tick();
        m.wr_en = 1'b0;
        chk("busy_wr_err", 64'(m.wr_err), 64'd1);
        m.clear = 1'b1;
        tick();
        m.clear = 1'b0;
        chk("busy_clear_no_err", 64'(m.wr_err), 64'd0);
        wait_done(n);
        chk("busywr_latency", 64'(n), 64'd2);
        chk_sums("oor", 27);
        chk_pulse_end("busywr");
        start_pulse(1'b0);
        wait_done(n);
        chk_sums("after_busywr", 27);
        chk_mesh("after_busywr");
        tick();

        // start with simultaneous write: row 4 old 01 -> 11
        m.start = 1'b1; m.mode = 1'b0;
        m.wr_en = 1'b1; m.wr_row = 5'd4; m.wr_data = fill(2'b11);
        tick();
        m.start = 1'b0; m.wr_en = 1'b0;
        wait_done(n);
        chk("sim_latency", 64'(n), 64'd4);
        chk_sums("sim_old", 27);
        chk("sim_row4_old", 64'(m.out_mesh[4*52 +: 52]), 64'(fill(2'b01)));
        mrow[4] = fill(2'b11);
        tick();
        start_pulse(1'b0);
        wait_done(n);
        chk_sums("sim_new", 29);
        chk_mesh("sim_new");
        tick();

        // reset two cycles into RUN
        load_base();
        start_pulse(1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(m.busy), 64'd0);
        chk("arst_valid", 64'(m.out_valid), 64'd0);
        chk("arst_mesh_or", 64'(|m.out_mesh), 64'd0);
        chk("arst_colsum_or", 64'(|m.out_colsum), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 18; r++) mrow[r] = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m.out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        start_pulse(1'b0);
        wait_done(n);
        chk_sums("arst_zero", 0);
        tick();
        load_base();
        start_pulse(1'b0);
        wait_done(n);
        chk("arst_fresh_latency", 64'(n), 64'd4);
        chk_sums("arst_fresh", 27);
        chk_pulse_end("arst_fresh");

        // small instance: W=4, COLS=8, ROWS=5, LATENCY=2
        for (int i = 0; i < 5; i++) begin
            s.wr_en = 1'b1; s.wr_row = 3'(i); s.wr_data = '1;
            tick();
        end
        s.wr_en = 1'b0;
        s.start = 1'b1; s.mode = 1'b0;
        tick();
        s.start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s.out_valid && n < 20);
        chk("sw_latency", 64'(n), 64'd2);
        for (int c = 0; c < 8; c++)
            chk($sformatf("sw_col%0d", c), 64'(s.out_colsum[c*7 +: 7]), 64'd75);
        chk("sw_mesh_all1", 64'(&s.out_mesh), 64'd1);
        tick();
        chk("sw_valid_one_cycle", 64'(s.out_valid), 64'd0);
        s.clear = 1'b1;
        tick();
        s.clear = 1'b0;
        s.start = 1'b1;
        tick();
        s.start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s.out_valid && n < 20);
        chk("sw_clr_latency", 64'(n), 64'd2);
        for (int c = 0; c < 8; c++)
            chk($sformatf("sw_clr_col%0d", c), 64'(s.out_colsum[c*7 +: 7]), 64'd0);
        chk("sw_clr_mesh_or", 64'(|s.out_mesh), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
